// File: rtl/mem_access_unit.sv
// Data-RAM bus initiator: turns one load/store request into a single bus transaction.
// Latency: load done at N+2+READ_LATENCY, store done at N+2, rejected request done at N+1.
// Backpressure: none; start is sampled only in IDLE and is ignored while busy (no queueing).
//
// Ports:
//   clk_i, reset_i          clock and synchronous active-high reset
//   start_i, op_i           request strobe and opcode (LB..LWR = 0..6, SB/SH/SW = 8/9/10)
//   addr_i                  byte address; store_data_i store value; rt_old_i merge source for LWL/LWR
//   busy_o, done_o, err_o   status; err_o and load_result_o are valid with done_o
//   mem_*                   word-aligned RAM bus (address, byteenable, read, write, writedata, readdata)
module mem_access_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rt_old_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] load_result_o,
  output logic [31:0] mem_address_o,
  output logic [3:0]  mem_byteenable_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_writedata_o,
  input  logic [31:0] mem_readdata_i
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  // WAIT lasts READ_LATENCY cycles; the counter counts down to zero on the capture edge.
  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FIN} state_t;

  state_t      state_q;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] rt_old_q;
  logic [2:0]  wait_cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] load_result_q;
  logic [31:0] mem_address_q;
  logic [3:0]  mem_byteenable_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_writedata_q;

  // Request decode, evaluated on the incoming request.
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_is_load;
  logic [3:0]  req_be_d;
  logic [31:0] req_wdata_d;

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_is_load    = ~op_i[3];
    req_be_d       = 4'b1111;
    req_wdata_d    = '0;
    case (op_i)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: req_misaligned = 1'b0;
      OP_LH, OP_LHU:                 req_misaligned = addr_i[0];
      OP_LW:                         req_misaligned = |addr_i[1:0];
      OP_SB: begin
        req_be_d    = 4'b0001 << addr_i[1:0];
        req_wdata_d = {4{store_data_i[7:0]}};
      end
      OP_SH: begin
        req_misaligned = addr_i[0];
        req_be_d       = addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata_d    = {2{store_data_i[15:0]}};
      end
      OP_SW: begin
        req_misaligned = |addr_i[1:0];
        req_wdata_d    = store_data_i;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Load formatting from the returned word; lanes are selected by shifting the
  // addressed byte down to bit 0 (LH/LHU only ever see lane 0 or 2 here).
  logic [4:0]  lane_shamt;
  logic [4:0]  lwl_shamt;
  logic [31:0] rd_shifted;
  logic [31:0] load_result_d;

  always_comb begin
    lane_shamt    = {lane_q, 3'b000};
    lwl_shamt     = {~lane_q, 3'b000};  // 8*(3-k)
    rd_shifted    = mem_readdata_i >> lane_shamt;
    load_result_d = mem_readdata_i;
    case (op_q)
      OP_LB:  load_result_d = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      OP_LBU: load_result_d = {24'd0, rd_shifted[7:0]};
      OP_LH:  load_result_d = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      OP_LHU: load_result_d = {16'd0, rd_shifted[15:0]};
      // Keep mask written as ~(ones << n) so k=3 never needs a 32-bit shift.
      OP_LWL: load_result_d = (mem_readdata_i << lwl_shamt)
                              | (rt_old_q & ~(32'hFFFF_FFFF << lwl_shamt));
      OP_LWR: load_result_d = rd_shifted
                              | (rt_old_q & ~(32'hFFFF_FFFF >> lane_shamt));
      default: load_result_d = mem_readdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      op_q             <= '0;
      lane_q           <= '0;
      rt_old_q         <= '0;
      wait_cnt_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      load_result_q    <= '0;
      mem_address_q    <= '0;
      mem_byteenable_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
    end else begin
      // Strobes and done are single-cycle pulses unless re-asserted below.
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            lane_q   <= addr_i[1:0];
            rt_old_q <= rt_old_i;
            busy_q   <= 1'b1;
            if (req_illegal || req_misaligned) begin
              state_q       <= S_FIN;
              err_q         <= 1'b1;
              done_q        <= 1'b1;
              load_result_q <= '0;
            end else begin
              state_q          <= S_REQ;
              mem_address_q    <= {addr_i[31:2], 2'b00};
              mem_byteenable_q <= req_be_d;
              mem_writedata_q  <= req_wdata_d;
              mem_read_q       <= req_is_load;
              mem_write_q      <= ~req_is_load;
            end
          end
        end
        S_REQ: begin
          if (!op_q[3]) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= WAIT_INIT;
          end else begin
            state_q          <= S_FIN;
            done_q           <= 1'b1;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_writedata_q  <= '0;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q          <= S_FIN;
            done_q           <= 1'b1;
            load_result_q    <= load_result_d;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_writedata_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign load_result_o    = load_result_q;
  assign mem_address_o    = mem_address_q;
  assign mem_byteenable_o = mem_byteenable_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;
  assign mem_writedata_o  = mem_writedata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: instance a has READ_LATENCY=1, instance b has READ_LATENCY=3.
// Both share one RAM model; expected completions go into a scoreboard queue,
// and a negedge monitor pops and compares whenever a done pulse appears.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [3:0]  op;
  logic [31:0] addr, sdata, rt_old;

  logic        busy_a, done_a, err_a, rd_a, wr_a;
  logic [31:0] res_a, adr_a, wd_a, rdata_a;
  logic [3:0]  be_a;
  logic        busy_b, done_b, err_b, rd_b, wr_b;
  logic [31:0] res_b, adr_b, wd_b, rdata_b;
  logic [3:0]  be_b;

  mem_access_unit #(.READ_LATENCY(1)) u_a (
    .clk_i(clk), .reset_i(reset), .start_i(start_a), .op_i(op), .addr_i(addr),
    .store_data_i(sdata), .rt_old_i(rt_old), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .load_result_o(res_a), .mem_address_o(adr_a),
    .mem_byteenable_o(be_a), .mem_read_o(rd_a), .mem_write_o(wr_a),
    .mem_writedata_o(wd_a), .mem_readdata_i(rdata_a)
  );

  mem_access_unit #(.READ_LATENCY(3)) u_b (
    .clk_i(clk), .reset_i(reset), .start_i(start_b), .op_i(op), .addr_i(addr),
    .store_data_i(sdata), .rt_old_i(rt_old), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .load_result_o(res_b), .mem_address_o(adr_b),
    .mem_byteenable_o(be_b), .mem_read_o(rd_b), .mem_write_o(wr_b),
    .mem_writedata_o(wd_b), .mem_readdata_i(rdata_b)
  );

  // RAM model: read data appears for exactly one cycle, READ_LATENCY cycles
  // after the edge that sampled mem_read; otherwise it drives a junk pattern.
  logic [31:0] mem [0:255];
  logic [31:0] pa_d;
  logic        pa_v = 1'b0;
  logic [31:0] pb_d [0:2];
  logic [2:0]  pb_v = 3'b000;
  int          cyc = 0;
  logic        rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
    if (cyc == 0) begin
      for (int j = 0; j < 256; j++) mem[j] <= '0;
      mem[64] <= 32'h8765_43A1;  // word at 0x100
    end
    pa_v     <= rd_a;
    pa_d     <= mem[adr_a[9:2]];
    pb_v     <= {pb_v[1:0], rd_b};
    pb_d[0]  <= mem[adr_b[9:2]];
    pb_d[1]  <= pb_d[0];
    pb_d[2]  <= pb_d[1];
    for (int l = 0; l < 4; l++) begin
      if (wr_a && be_a[l]) mem[adr_a[9:2]][8*l +: 8] <= wd_a[8*l +: 8];
      if (wr_b && be_b[l]) mem[adr_b[9:2]][8*l +: 8] <= wd_b[8*l +: 8];
    end
  end

  assign rdata_a = pa_v    ? pa_d    : 32'hDEAD_BEEF;
  assign rdata_b = pb_v[2] ? pb_d[2] : 32'hDEAD_BEEF;

  // Scoreboard.
  typedef struct {
    int          inst;
    int          tag;
    int          t_start;
    int          lat;
    logic        err;
    logic        chk_res;
    logic [31:0] res;
    int          nrd;
    int          nwr;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          nbusy [2];
  int          nrd   [2];
  int          nwr   [2];
  logic [31:0] s_adr [2];
  logic [31:0] s_wd  [2];
  logic [3:0]  s_be  [2];

  task automatic cmp(input int tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL txn%0d %s: got 0x%08h, want 0x%08h", tag, what, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic bsy, input logic dn, input logic er,
                     input logic rd, input logic wr, input logic [31:0] res,
                     input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    if (rst_q) begin
      cmp(900 + i, "reset_flags", {27'd0, bsy, dn, er, rd, wr}, 32'd0);
      cmp(900 + i, "reset_load_result", res, 32'd0);
      cmp(900 + i, "reset_address", adr, 32'd0);
      cmp(900 + i, "reset_byteenable", {28'd0, be}, 32'd0);
      cmp(900 + i, "reset_writedata", wd, 32'd0);
      nbusy[i] = 0; nrd[i] = 0; nwr[i] = 0;
      return;
    end
    if (bsy) nbusy[i]++;
    if (rd)  nrd[i]++;
    if (wr)  nwr[i]++;
    if (rd || wr) begin
      s_adr[i] = adr; s_be[i] = be; s_wd[i] = wd;
    end
    if (dn) begin
      if (sb_q.size() == 0 || sb_q[0].inst != i) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done inst%0d: got done=1, want no completion", i);
      end else begin
        e = sb_q.pop_front();
        cmp(e.tag, "latency", cyc - e.t_start, e.lat);
        cmp(e.tag, "err", {31'd0, er}, {31'd0, e.err});
        cmp(e.tag, "busy_cycles", nbusy[i], e.lat);
        cmp(e.tag, "read_pulses", nrd[i], e.nrd);
        cmp(e.tag, "write_pulses", nwr[i], e.nwr);
        if (e.chk_res) cmp(e.tag, "load_result", res, e.res);
        if (e.nrd + e.nwr > 0) begin
          cmp(e.tag, "address", s_adr[i], e.adr);
          cmp(e.tag, "byteenable", {28'd0, s_be[i]}, {28'd0, e.be});
        end
        if (e.nwr > 0) cmp(e.tag, "writedata", s_wd[i], e.wd);
      end
      nbusy[i] = 0; nrd[i] = 0; nwr[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, busy_a, done_a, err_a, rd_a, wr_a, res_a, adr_a, wd_a, be_a);
    mon(1, busy_b, done_b, err_b, rd_b, wr_b, res_b, adr_b, wd_b, be_b);
    if (sb_q.size() > 0 && cyc - sb_q[0].t_start > 15) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn%0d timeout: got no done after %0d cycles, want done", sb_q[0].tag, cyc - sb_q[0].t_start);
      void'(sb_q.pop_front());
    end
  end

  // Stimulus: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input exp_t e_in, input logic [3:0] o, input logic [31:0] a,
                    input logic [31:0] sd, input logic [31:0] rt, input bit extra);
    exp_t e;
    e = e_in;
    op = o; addr = a; sdata = sd; rt_old = rt;
    if (e.inst == 0) start_a = 1'b1; else start_b = 1'b1;
    e.t_start = cyc;  // cycle N: start is visible during this cycle
    sb_q.push_back(e);
    tick();
    start_a = 1'b0; start_b = 1'b0;
    if (extra) begin
      // A second start while busy must be dropped.
      tick();
      op = 4'd0; addr = 32'h0000_0101;
      if (e.inst == 0) start_a = 1'b1; else start_b = 1'b1;
      tick();
      start_a = 1'b0; start_b = 1'b0;
    end
    for (int w = 0; w < 40 && sb_q.size() != 0; w++) tick();
    repeat (3) tick();
  endtask

  task automatic ld(input int inst, input int tag, input logic [3:0] o, input logic [31:0] a,
                    input logic [31:0] rt, input logic [31:0] res, input logic [31:0] wadr, input bit extra);
    exp_t e;
    e.inst = inst; e.tag = tag; e.t_start = 0; e.lat = (inst == 0) ? 3 : 5;
    e.err = 1'b0; e.chk_res = 1'b1; e.res = res; e.nrd = 1; e.nwr = 0;
    e.adr = wadr; e.be = 4'b1111; e.wd = 32'd0;
    go(e, o, a, 32'h5555_AAAA, rt, extra);
  endtask

  task automatic st(input int inst, input int tag, input logic [3:0] o, input logic [31:0] a,
                    input logic [31:0] sd, input logic [31:0] wadr, input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    e.inst = inst; e.tag = tag; e.t_start = 0; e.lat = 2;
    e.err = 1'b0; e.chk_res = 1'b0; e.res = 32'd0; e.nrd = 0; e.nwr = 1;
    e.adr = wadr; e.be = be; e.wd = wd;
    go(e, o, a, sd, 32'h0, 1'b0);
  endtask

  task automatic bad(input int inst, input int tag, input logic [3:0] o, input logic [31:0] a);
    exp_t e;
    e.inst = inst; e.tag = tag; e.t_start = 0; e.lat = 1;
    e.err = 1'b1; e.chk_res = 1'b1; e.res = 32'd0; e.nrd = 0; e.nwr = 0;
    e.adr = 32'd0; e.be = 4'd0; e.wd = 32'd0;
    go(e, o, a, 32'hFFFF_FFFF, 32'h1122_3344, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    op = 4'd0; addr = 32'd0; sdata = 32'd0; rt_old = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Loads, READ_LATENCY=1, word 0x100 = 0x876543A1.
    ld(0,  1, 4'd0, 32'h101, 32'h1122_3344, 32'h0000_0043, 32'h100, 1'b0);  // LB
    ld(0,  2, 4'd0, 32'h103, 32'h1122_3344, 32'hFFFF_FF87, 32'h100, 1'b0);  // LB
    ld(0,  3, 4'd1, 32'h103, 32'h1122_3344, 32'h0000_0087, 32'h100, 1'b0);  // LBU
    ld(0,  4, 4'd2, 32'h102, 32'h1122_3344, 32'hFFFF_8765, 32'h100, 1'b0);  // LH
    ld(0,  5, 4'd3, 32'h102, 32'h1122_3344, 32'h0000_8765, 32'h100, 1'b0);  // LHU
    ld(0,  6, 4'd0, 32'h100, 32'h1122_3344, 32'hFFFF_FFA1, 32'h100, 1'b0);  // LB
    ld(0,  7, 4'd2, 32'h100, 32'h1122_3344, 32'h0000_43A1, 32'h100, 1'b0);  // LH
    ld(0,  8, 4'd4, 32'h100, 32'h1122_3344, 32'h8765_43A1, 32'h100, 1'b0);  // LW
    ld(0,  9, 4'd5, 32'h101, 32'h1122_3344, 32'h43A1_3344, 32'h100, 1'b0);  // LWL
    ld(0, 10, 4'd6, 32'h101, 32'h1122_3344, 32'h1187_6543, 32'h100, 1'b0);  // LWR
    ld(0, 11, 4'd5, 32'h103, 32'h1122_3344, 32'h8765_43A1, 32'h100, 1'b0);  // LWL
    ld(0, 12, 4'd6, 32'h100, 32'h1122_3344, 32'h8765_43A1, 32'h100, 1'b0);  // LWR
    ld(0, 13, 4'd5, 32'h100, 32'h1122_3344, 32'hA122_3344, 32'h100, 1'b0);  // LWL k=0
    ld(0, 14, 4'd6, 32'h103, 32'h1122_3344, 32'h1122_3387, 32'h100, 1'b0);  // LWR k=3

    // Rejected requests.
    bad(0, 20, 4'd4,  32'h102);  // LW misaligned
    bad(0, 21, 4'd9,  32'h101);  // SH misaligned
    bad(0, 22, 4'd7,  32'h100);  // illegal op
    bad(0, 23, 4'd15, 32'h100);  // illegal op
    bad(0, 24, 4'd3,  32'h103);  // LHU misaligned
    bad(0, 25, 4'd10, 32'h101);  // SW misaligned

    // Loads, READ_LATENCY=3.
    ld(1, 30, 4'd0, 32'h103, 32'h1122_3344, 32'hFFFF_FF87, 32'h100, 1'b0);
    ld(1, 31, 4'd3, 32'h102, 32'h1122_3344, 32'h0000_8765, 32'h100, 1'b0);
    ld(1, 32, 4'd6, 32'h101, 32'h1122_3344, 32'h1187_6543, 32'h100, 1'b0);
    ld(1, 33, 4'd4, 32'h100, 32'h1122_3344, 32'h8765_43A1, 32'h100, 1'b1);  // start again while busy
    bad(1, 35, 4'd2, 32'h101);

    // Reset during WAIT on instance b: no done may follow.
    op = 4'd4; addr = 32'h100; start_b = 1'b1;
    tick();          // REQ
    start_b = 1'b0;
    tick();          // WAIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    ld(1, 34, 4'd4, 32'h100, 32'h0, 32'h8765_43A1, 32'h100, 1'b0);

    // Stores, then read back the merged word.
    st(0, 40, 4'd8,  32'h102, 32'h0000_00CC, 32'h100, 4'b0100, 32'hCCCC_CCCC);  // 87CC43A1
    st(0, 41, 4'd9,  32'h102, 32'h0000_BEEF, 32'h100, 4'b1100, 32'hBEEF_BEEF);  // BEEF43A1
    st(0, 42, 4'd8,  32'h101, 32'h1234_5677, 32'h100, 4'b0010, 32'h7777_7777);  // BEEF77A1
    st(0, 43, 4'd9,  32'h100, 32'h0000_5A5A, 32'h100, 4'b0011, 32'h5A5A_5A5A);  // BEEF5A5A
    ld(1, 44, 4'd4, 32'h100, 32'h0, 32'hBEEF_5A5A, 32'h100, 1'b0);
    st(1, 45, 4'd10, 32'h104, 32'hDEAD_C0DE, 32'h104, 4'b1111, 32'hDEAD_C0DE);
    ld(0, 46, 4'd4, 32'h104, 32'h0, 32'hDEAD_C0DE, 32'h104, 1'b0);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
